// File: rtl/regfile_pkg.sv
// Shared defaults and condition-code encodings for the regfile_cc block.
package regfile_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 8;
    localparam int DEF_NRD   = 2;

    typedef logic [2:0] cc_t;

    localparam cc_t CC_N = 3'b100;
    localparam cc_t CC_Z = 3'b010;
    localparam cc_t CC_P = 3'b001;

endpackage

// File: rtl/regfile_cc_if.sv
// Register-file bus: write, read, condition-code and scoreboard signals.
// The write data is called global_i because `global` is a reserved word in SystemVerilog.
interface regfile_cc_if
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int NRD   = DEF_NRD
);
    localparam int AW = $clog2(DEPTH);

    logic                 ld_reg;
    logic [AW-1:0]        DR;
    logic [WIDTH-1:0]     global_i;
    logic [NRD*AW-1:0]    SR;
    logic [NRD*WIDTH-1:0] SR_OUT;
    logic                 ld_cc;
    logic [2:0]           NZP;
    logic                 mark_busy;
    logic [AW-1:0]        mark_dr;
    logic [NRD-1:0]       SR_BUSY;
    logic [DEPTH-1:0]     busy;

    modport master (
        output ld_reg, DR, global_i, SR, ld_cc, mark_busy, mark_dr,
        input  SR_OUT, NZP, SR_BUSY, busy
    );

    modport slave (
        input  ld_reg, DR, global_i, SR, ld_cc, mark_busy, mark_dr,
        output SR_OUT, NZP, SR_BUSY, busy
    );

endinterface

// File: rtl/regfile_cc_nzp_gen.sv
// Combinational encoder from a data word to its one-hot {N,Z,P} condition code.
module nzp_gen
    import regfile_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] data_i,
    output cc_t              nzp_o
);

    always_comb begin
        if (data_i[WIDTH-1]) begin
            nzp_o = CC_N;
        end else if (data_i == '0) begin
            nzp_o = CC_Z;
        end else begin
            nzp_o = CC_P;
        end
    end

endmodule

// File: rtl/regfile_cc.sv
// Multi-port register file with registered reads, optional write bypass,
// condition codes and a pending-write scoreboard.
module regfile_cc
    import regfile_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NRD    = DEF_NRD,
    parameter int BYPASS = 0
) (
    input  logic        clk,
    input  logic        reset,
    regfile_cc_if.slave bus
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0]     regs_q [DEPTH];
    logic [DEPTH-1:0]     busy_q, busy_d;
    cc_t                  nzp_q, nzp_d, nzp_new;
    logic [NRD*WIDTH-1:0] sr_out_q, sr_out_d;
    logic [NRD-1:0]       sr_busy_q, sr_busy_d;
    logic [AW-1:0]        rd_sel [NRD];

    nzp_gen #(.WIDTH(WIDTH)) u_nzp_gen (
        .data_i (bus.global_i),
        .nzp_o  (nzp_new)
    );

    always_comb begin
        for (int i = 0; i < NRD; i++) begin
            rd_sel[i] = bus.SR[i*AW +: AW];
        end
    end

    // A mark on the same register as a write wins: the new pending write is still outstanding.
    always_comb begin
        busy_d = busy_q;
        if (bus.ld_reg) begin
            busy_d[bus.DR] = 1'b0;
        end
        if (bus.mark_busy) begin
            busy_d[bus.mark_dr] = 1'b1;
        end
    end

    assign nzp_d = bus.ld_cc ? nzp_new : nzp_q;

    // NOTE: every output of this block gets a default before the loop, so no latch is inferred.
    always_comb begin
        sr_out_d  = '0;
        sr_busy_d = '0;
        for (int i = 0; i < NRD; i++) begin
            if ((BYPASS != 0) && bus.ld_reg && (bus.DR == rd_sel[i])) begin
                sr_out_d[i*WIDTH +: WIDTH] = bus.global_i;
            end else begin
                sr_out_d[i*WIDTH +: WIDTH] = regs_q[rd_sel[i]];
            end
            sr_busy_d[i] = (BYPASS != 0) ? busy_d[rd_sel[i]] : busy_q[rd_sel[i]];
        end
    end

    // NOTE: the register array is built from flops and must read as zero straight after reset,
    // so it is cleared here rather than left to a RAM macro that cannot be reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                regs_q[k] <= '0;
            end
            busy_q    <= '0;
            nzp_q     <= CC_Z;
            sr_out_q  <= '0;
            sr_busy_q <= '0;
        end else begin
            if (bus.ld_reg) begin
                regs_q[bus.DR] <= bus.global_i;
            end
            busy_q    <= busy_d;
            nzp_q     <= nzp_d;
            sr_out_q  <= sr_out_d;
            sr_busy_q <= sr_busy_d;
        end
    end

    assign bus.SR_OUT  = sr_out_q;
    assign bus.SR_BUSY = sr_busy_q;
    assign bus.NZP     = nzp_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_regfile_cc.sv
// Directed bench: BYPASS=0 and BYPASS=1 default instances driven in lockstep,
// plus a 32x16, three-port instance.
module tb_regfile_cc;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic        ld_reg    = 1'b0;
    logic [2:0]  dr        = '0;
    logic [15:0] glob      = '0;
    logic [5:0]  sr        = '0;
    logic        ld_cc     = 1'b0;
    logic        mark_busy = 1'b0;
    logic [2:0]  mark_dr   = '0;

    regfile_cc_if #(.WIDTH(16), .DEPTH(8),  .NRD(2)) bus0 ();
    regfile_cc_if #(.WIDTH(16), .DEPTH(8),  .NRD(2)) bus1 ();
    regfile_cc_if #(.WIDTH(32), .DEPTH(16), .NRD(3)) bus2 ();

    assign bus0.ld_reg    = ld_reg;
    assign bus0.DR        = dr;
    assign bus0.global_i  = glob;
    assign bus0.SR        = sr;
    assign bus0.ld_cc     = ld_cc;
    assign bus0.mark_busy = mark_busy;
    assign bus0.mark_dr   = mark_dr;

    assign bus1.ld_reg    = ld_reg;
    assign bus1.DR        = dr;
    assign bus1.global_i  = glob;
    assign bus1.SR        = sr;
    assign bus1.ld_cc     = ld_cc;
    assign bus1.mark_busy = mark_busy;
    assign bus1.mark_dr   = mark_dr;

    regfile_cc #(.WIDTH(16), .DEPTH(8),  .NRD(2), .BYPASS(0)) u_dut0 (.clk(clk), .reset(rst), .bus(bus0));
    regfile_cc #(.WIDTH(16), .DEPTH(8),  .NRD(2), .BYPASS(1)) u_dut1 (.clk(clk), .reset(rst), .bus(bus1));
    regfile_cc #(.WIDTH(32), .DEPTH(16), .NRD(3), .BYPASS(0)) u_dut2 (.clk(clk), .reset(rst), .bus(bus2));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus2.ld_reg    = 1'b0;
        bus2.DR        = '0;
        bus2.global_i  = '0;
        bus2.SR        = '0;
        bus2.ld_cc     = 1'b0;
        bus2.mark_busy = 1'b0;
        bus2.mark_dr   = '0;

        // Reset held: everything cleared, NZP at Z
        repeat (2) step();
        check("rst_sr_out0", bus0.SR_OUT, 32'h0);
        check("rst_nzp0",    bus0.NZP, 3'b010);
        check("rst_busy0",   bus0.busy, 8'h00);
        check("rst_sr_out2", bus2.SR_OUT, 96'h0);
        check("rst_nzp2",    bus2.NZP, 3'b010);
        rst = 1'b0;

        // All registers read zero on both ports
        for (int r = 0; r < 8; r++) begin
            sr = {r[2:0], r[2:0]};
            step();
            check($sformatf("rd0_r%0d", r), bus0.SR_OUT, 32'h0);
            check($sformatf("rd1_r%0d", r), bus1.SR_OUT, 32'h0);
        end
        check("idle_nzp",  bus0.NZP, 3'b010);
        check("idle_busy", bus0.busy, 8'h00);

        // Negative write with CC load, then read back
        ld_reg = 1'b1; dr = 3'd3; glob = 16'h8001; ld_cc = 1'b1;
        step();
        ld_reg = 1'b0; ld_cc = 1'b0;
        sr = {3'd0, 3'd3};
        step();
        check("r3_read", bus0.SR_OUT[15:0], 16'h8001);
        check("r3_nzp",  bus0.NZP, 3'b100);

        // Same-edge write/read of R5: old value without bypass, new value with
        ld_reg = 1'b1; dr = 3'd5; glob = 16'h00FF;
        step();
        glob = 16'h1234; sr = {3'd5, 3'd3};
        step();
        ld_reg = 1'b0;
        check("byp0_r5", bus0.SR_OUT[31:16], 16'h00FF);
        check("byp1_r5", bus1.SR_OUT[31:16], 16'h1234);
        check("byp0_r3", bus0.SR_OUT[15:0],  16'h8001);
        check("byp1_r3", bus1.SR_OUT[15:0],  16'h8001);
        step();
        check("r5_after", bus0.SR_OUT[31:16], 16'h1234);
        check("same_reg", bus0.SR_OUT[15:0],  16'h8001);

        // Scoreboard
        mark_busy = 1'b1; mark_dr = 3'd2;
        step();
        mark_busy = 1'b0;
        check("mark_r2", bus0.busy, 8'h04);
        sr = {3'd0, 3'd2};
        step();
        check("sr_busy_r2", bus0.SR_BUSY[0], 1'b1);
        ld_reg = 1'b1; dr = 3'd2; glob = 16'h0042; mark_busy = 1'b1; mark_dr = 3'd2;
        step();
        mark_busy = 1'b0;
        check("mark_wins", bus0.busy, 8'h04);
        step();
        ld_reg = 1'b0;
        check("clr_busy0",  bus0.busy, 8'h00);
        check("clr_busy1",  bus1.busy, 8'h00);
        check("sr_busy_pre",  bus0.SR_BUSY[0], 1'b1);
        check("sr_busy_post", bus1.SR_BUSY[0], 1'b0);

        // CC zero and positive, write-free
        ld_cc = 1'b1; glob = 16'h0000;
        step();
        check("cc_zero", bus0.NZP, 3'b010);
        glob = 16'h7FFF;
        step();
        ld_cc = 1'b0;
        check("cc_pos", bus0.NZP, 3'b001);
        sr = {3'd0, 3'd3}; mark_busy = 1'b1; mark_dr = 3'd6;
        step();
        mark_busy = 1'b0;
        check("pre_rst_rd",   bus0.SR_OUT, 32'h0000_8001);
        check("pre_rst_busy", bus0.busy, 8'h40);

        // Asynchronous reset between edges
        #2 rst = 1'b1;
        #1;
        check("arst_nzp",    bus0.NZP, 3'b010);
        check("arst_sr_out", bus0.SR_OUT, 32'h0);
        check("arst_busy",   bus0.busy, 8'h00);

        // Writes, CC loads and marks under reset are dropped
        ld_reg = 1'b1; dr = 3'd4; glob = 16'hABCD; ld_cc = 1'b1;
        mark_busy = 1'b1; mark_dr = 3'd4; sr = {3'd4, 3'd4};
        step();
        rst = 1'b0;
        ld_reg = 1'b0; ld_cc = 1'b0; mark_busy = 1'b0;
        step();
        check("rst_drop_r4",   bus0.SR_OUT, 32'h0);
        check("rst_drop_nzp",  bus0.NZP, 3'b010);
        check("rst_drop_busy", bus0.busy, 8'h00);
        sr = {3'd3, 3'd3};
        step();
        check("rst_clr_r3", bus0.SR_OUT, 32'h0);

        // Wide instance: R15 all ones on all three ports
        bus2.ld_reg = 1'b1; bus2.DR = 4'd15; bus2.global_i = 32'hFFFF_FFFF; bus2.ld_cc = 1'b1;
        step();
        bus2.ld_reg = 1'b0; bus2.ld_cc = 1'b0;
        bus2.SR = {4'd15, 4'd15, 4'd15};
        step();
        check("wide_rd",  bus2.SR_OUT, {32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
        check("wide_nzp", bus2.NZP, 3'b100);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
